// File: rtl/uart_fifo_tx_param_if.sv
// Byte-push / serial-line bundle for the FIFO-buffered UART transmitter.
// master: dat_en, dat, ovf_clr out; TX and FIFO status in. slave: mirror.
interface uart_fifo_tx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 12
);
  logic                 dat_en;
  logic [DATA_BITS-1:0] dat;
  logic                 ovf_clr;
  logic                 TX;
  logic                 fifo_empty;
  logic                 fifo_afull;
  logic                 fifo_full;
  logic [FIFO_AW:0]     fifo_count;
  logic                 busy;
  logic                 overflow;

  modport master (
    output dat_en, dat, ovf_clr,
    input  TX, fifo_empty, fifo_afull, fifo_full,
    input  fifo_count, busy, overflow
  );

  modport slave (
    input  dat_en, dat, ovf_clr,
    output TX, fifo_empty, fifo_afull, fifo_full,
    output fifo_count, busy, overflow
  );
endinterface

// File: rtl/uart_fifo_tx_param.sv
// Parametrised FIFO-buffered UART transmitter (data/parity/stop configurable).
// Ports: clk_100MHz, reset_n (sync, active-low), bus (slave: push side + TX/status).
module uart_fifo_tx_param #(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 12,
  parameter int AFULL_LVL = 4090
) (
  input logic                 clk_100MHz,
  input logic                 reset_n,
  uart_fifo_tx_param_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  localparam logic [15:0] BAUD_TOP  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic        PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  state_t               r_state;
  state_t               w_state_nx;
  logic [15:0]          r_baud;
  logic [15:0]          w_baud_nx;
  logic [3:0]           r_bit;
  logic [3:0]           w_bit_nx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 r_par;
  logic                 w_par_nx;
  logic                 r_tx;
  logic                 w_tx_nx;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_tick;
  logic [DATA_BITS-1:0] w_rd_data;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_tick    = (r_baud == '0);
  assign w_rd_data = r_mem[r_rd_ptr];

  // A pop frees a slot in the same edge, so a full FIFO still
  // accepts a push when the transmitter is taking an entry.
  assign w_push = bus.dat_en && (!w_full || w_pop);
  assign w_drop = bus.dat_en && w_full && !w_pop;

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = w_tick ? '0 : r_baud - 16'd1;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_tx_nx    = r_tx;
    w_pop      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_pop = (r_count != '0);
      end
      S_START: begin
        if (w_tick) begin
          w_state_nx = S_DATA;
          w_tx_nx    = r_shift[0];
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = '0;
          w_baud_nx  = BAUD_TOP;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_nx = BAUD_TOP;
          if (r_bit == LAST_DATA) begin
            w_bit_nx = '0;
            if (PARITY != 0) begin
              w_state_nx = S_PAR;
              w_tx_nx    = r_par;
            end else begin
              w_state_nx = S_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bit_nx   = r_bit + 4'd1;
            w_tx_nx    = r_shift[0];
            w_shift_nx = r_shift >> 1;
          end
        end
      end
      S_PAR: begin
        if (w_tick) begin
          w_state_nx = S_STOP;
          w_tx_nx    = 1'b1;
          w_bit_nx   = '0;
          w_baud_nx  = BAUD_TOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit == LAST_STOP) begin
            // Final stop cycle: chain straight into the next
            // frame when data is waiting, else go idle.
            w_state_nx = S_IDLE;
            w_pop      = (r_count != '0);
          end else begin
            w_bit_nx  = r_bit + 4'd1;
            w_baud_nx = BAUD_TOP;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase

    if (w_pop) begin
      w_state_nx = S_START;
      w_tx_nx    = 1'b0;
      w_baud_nx  = BAUD_TOP;
      w_bit_nx   = '0;
      w_shift_nx = w_rd_data;
      w_par_nx   = (^w_rd_data) ^ PAR_ODD;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_par   <= w_par_nx;
      r_tx    <= w_tx_nx;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage is never reset; only the pointers define valid data.
  always_ff @(posedge clk_100MHz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.dat;
    end
  end

  assign bus.TX         = r_tx;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.fifo_empty = (r_count == '0);
  assign bus.fifo_afull = (r_count >= CW'(AFULL_LVL));
  assign bus.fifo_full  = w_full;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_uart_fifo_tx_param.sv
// Self-checking bench for uart_fifo_tx_param: queue/frame reference model.
// Three instances cover no parity, even parity, and odd parity with two stops.
module tb_uart_fifo_tx_param;

  localparam int CD  = 4;
  localparam int FL0 = CD * 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_fifo_tx_param_if #(.DATA_BITS(8), .FIFO_AW(3)) a0 ();
  uart_fifo_tx_param_if #(.DATA_BITS(8), .FIFO_AW(3)) a1 ();
  uart_fifo_tx_param_if #(.DATA_BITS(8), .FIFO_AW(3)) a2 ();

  uart_fifo_tx_param #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .FIFO_AW(3), .AFULL_LVL(6)
  ) dut0 (.clk_100MHz(clk), .reset_n(rst_n), .bus(a0));

  uart_fifo_tx_param #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
    .FIFO_AW(3), .AFULL_LVL(6)
  ) dut1 (.clk_100MHz(clk), .reset_n(rst_n), .bus(a1));

  uart_fifo_tx_param #(
    .CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
    .FIFO_AW(3), .AFULL_LVL(6)
  ) dut2 (.clk_100MHz(clk), .reset_n(rst_n), .bus(a2));

  int n_pass = 0;
  int n_total = 0;

  // Reference model for dut0: a byte queue plus the elapsed
  // cycle index into the current 40-cycle frame (-1 = idle).
  byte unsigned mq[$];
  int           m_t = -1;
  logic [9:0]   m_fr = '1;
  logic         m_ovf = 1'b0;
  logic [9:0]   m_exp = 10'b1010000000;

  always @(posedge clk) begin : model
    int          sz;
    bit          pop;
    byte unsigned b;
    if (!rst_n) begin
      mq.delete();
      m_t   = -1;
      m_ovf = 1'b0;
    end else begin
      sz  = mq.size();
      pop = (sz > 0) && (m_t < 0 || m_t == FL0 - 1);
      if (pop) begin
        b    = mq.pop_front();
        m_fr = {1'b1, b, 1'b0};
        m_t  = 0;
      end else if (m_t >= 0) begin
        m_t++;
        if (m_t == FL0) m_t = -1;
      end
      if (a0.dat_en && (sz < 8 || pop)) mq.push_back(a0.dat);
      if (a0.dat_en && !(sz < 8 || pop)) m_ovf = 1'b1;
      else if (a0.ovf_clr) m_ovf = 1'b0;
    end
    sz = mq.size();
    m_exp = {(m_t < 0) ? 1'b1 : m_fr[m_t / CD], m_t >= 0,
             sz == 0, sz >= 6, sz == 8, m_ovf, 4'(sz)};
  end

  function automatic logic [9:0] obs0();
    return {a0.TX, a0.busy, a0.fifo_empty, a0.fifo_afull,
            a0.fifo_full, a0.overflow, a0.fifo_count};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (obs0() !== 10'b1010000000)
      $display("FAIL reset0: got %b want %b", obs0(), 10'b1010000000);
    else n_pass++;
    n_total++;
    if ({a1.TX, a1.busy, a2.TX, a2.busy} !== 4'b1010)
      $display("FAIL reset12: got %b want 1010",
               {a1.TX, a1.busy, a2.TX, a2.busy});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int nb;
    nb = 0;
    @(negedge clk);
    a0.dat_en = 1'b1;
    a0.dat = 8'hA5;
    @(negedge clk);
    a0.dat_en = 1'b0;
    n_total++;
    if (obs0() !== m_exp || a0.fifo_empty !== 1'b0)
      $display("FAIL single_push: got %b want %b", obs0(), m_exp);
    else n_pass++;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (a0.busy === 1'b1) nb++;
      n_total++;
      if (obs0() !== m_exp)
        $display("FAIL single c%0d: got %b want %b", i, obs0(), m_exp);
      else n_pass++;
    end
    n_total++;
    if (nb !== 40 || a0.fifo_empty !== 1'b1)
      $display("FAIL single_busy: got %0d/%b want 40/1", nb, a0.fifo_empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int pk;
    int nb;
    pk = 0;
    nb = 0;
    for (int i = 0; i < 133; i++) begin
      @(negedge clk);
      if (int'(a0.fifo_count) > pk) pk = int'(a0.fifo_count);
      if (a0.busy === 1'b1) nb++;
      n_total++;
      if (obs0() !== m_exp)
        $display("FAIL b2b c%0d: got %b want %b", i, obs0(), m_exp);
      else n_pass++;
      a0.dat_en = (i < 3);
      a0.dat = 8'(i + 1);
    end
    n_total++;
    if (pk !== 2 || nb !== 120)
      $display("FAIL b2b_peak: got %0d/%0d want 2/120", pk, nb);
    else n_pass++;
  endtask

  task automatic test_fill;
    int ph;
    ph = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      n_total++;
      if (obs0() !== m_exp)
        $display("FAIL fill c%0d: got %b want %b", i, obs0(), m_exp);
      else n_pass++;
      if (i == 6 || i == 7) begin
        n_total++;
        if (a0.fifo_afull !== (i == 7))
          $display("FAIL afull c%0d: got %b want %b", i, a0.fifo_afull, i == 7);
        else n_pass++;
      end
      if (i == 10) begin
        n_total++;
        if ({a0.fifo_full, a0.overflow, a0.fifo_count} !== 6'b11_1000)
          $display("FAIL full_drop: got %b want 111000",
                   {a0.fifo_full, a0.overflow, a0.fifo_count});
        else n_pass++;
      end
      a0.dat_en = 1'b0;
      a0.ovf_clr = 1'b0;
      a0.dat = 8'($urandom);
      if (i < 10) a0.dat_en = 1'b1;
      else if (i == 12) a0.ovf_clr = 1'b1;
      else if (ph == 0 && m_t == FL0 - 1 && mq.size() == 8) begin
        a0.dat_en = 1'b1;
        ph = 1;
      end else if (ph == 1) begin
        a0.dat_en = 1'b1;
        a0.ovf_clr = 1'b1;
        ph = 2;
      end else if (ph == 2) begin
        a0.ovf_clr = 1'b1;
        ph = 3;
      end
    end
    n_total++;
    if (ph !== 3)
      $display("FAIL fill_phase: got %0d want 3", ph);
    else n_pass++;
  endtask

  task automatic test_simul;
    int ph;
    ph = 0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      n_total++;
      if (obs0() !== m_exp)
        $display("FAIL simul c%0d: got %b want %b", i, obs0(), m_exp);
      else n_pass++;
      if (ph == 1) begin
        n_total++;
        if (a0.fifo_count !== 4'd1)
          $display("FAIL simul_cnt: got %0d want 1", a0.fifo_count);
        else n_pass++;
        ph = 2;
      end
      a0.dat_en = 1'b0;
      a0.dat = 8'($urandom);
      if (i < 2) a0.dat_en = 1'b1;
      else if (ph == 0 && m_t == FL0 - 1 && mq.size() == 1) begin
        a0.dat_en = 1'b1;
        ph = 1;
      end
    end
    n_total++;
    if (ph !== 2)
      $display("FAIL simul_phase: got %0d want 2", ph);
    else n_pass++;
  endtask

  task automatic test_parity;
    logic [7:0]  b;
    logic [10:0] f1;
    logic [11:0] f2;
    logic [1:0]  e1;
    logic [1:0]  e2;
    for (int r = 0; r < 2; r++) begin
      b  = (r == 0) ? 8'h07 : 8'($urandom);
      f1 = {1'b1, ^b, b, 1'b0};
      f2 = {2'b11, ~^b, b, 1'b0};
      @(negedge clk);
      a1.dat_en = 1'b1;
      a1.dat = b;
      a2.dat_en = 1'b1;
      a2.dat = b;
      @(negedge clk);
      a1.dat_en = 1'b0;
      a2.dat_en = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        e1 = (c < 44) ? {f1[c / CD], 1'b1} : 2'b10;
        e2 = (c < 48) ? {f2[c / CD], 1'b1} : 2'b10;
        n_total++;
        if ({a1.TX, a1.busy} !== e1)
          $display("FAIL par_even b%h c%0d: got %b want %b",
                   b, c, {a1.TX, a1.busy}, e1);
        else n_pass++;
        n_total++;
        if ({a2.TX, a2.busy} !== e2)
          $display("FAIL par_odd2 b%h c%0d: got %b want %b",
                   b, c, {a2.TX, a2.busy}, e2);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int ph;
    ph = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      n_total++;
      if (obs0() !== m_exp)
        $display("FAIL rmid c%0d: got %b want %b", i, obs0(), m_exp);
      else n_pass++;
      a0.dat_en = 1'b0;
      a0.dat = 8'($urandom);
      if (ph == 1) begin
        rst_n = 1'b1;
        n_total++;
        if (obs0() !== 10'b1010000000)
          $display("FAIL rmid_state: got %b want 1010000000", obs0());
        else n_pass++;
        ph = 2;
      end else if (ph == 2) begin
        if (a0.TX !== 1'b1 || a0.busy !== 1'b0) begin
          n_total++;
          $display("FAIL rmid_quiet c%0d: got %b%b want 10", i, a0.TX, a0.busy);
        end
      end
      if (i < 3) a0.dat_en = 1'b1;
      else if (ph == 0 && m_t == 10) begin
        rst_n = 1'b0;
        ph = 1;
      end
    end
    n_total++;
    if (ph !== 2)
      $display("FAIL rmid_phase: got %0d want 2", ph);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    a0.dat_en = 1'b0; a0.dat = '0; a0.ovf_clr = 1'b0;
    a1.dat_en = 1'b0; a1.dat = '0; a1.ovf_clr = 1'b0;
    a2.dat_en = 1'b0; a2.dat = '0; a2.ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_simul();
    test_parity();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
